// File: rtl/gpc_pkg.sv
// Shared constants and types for the generalized parallel counter cells.
package gpc_pkg;

  localparam int unsigned GPC7_3_IN_W  = 7;
  localparam int unsigned GPC7_3_OUT_W = 3;

  typedef logic [GPC7_3_IN_W-1:0]  gpc7_3_in_t;
  typedef logic [GPC7_3_OUT_W-1:0] gpc7_3_out_t;

endpackage

// File: rtl/gpc_full_adder.sv
// One-bit full adder, the building cell of the GPC compressor trees.
module gpc_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/gpc_7_3.sv
// 7:3 generalized parallel counter built from a 4-cell full-adder tree.
// Optional registered output with valid tracking: define GPC_7_3_OUT_REG_EN.
module gpc_7_3
  import gpc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] src0,
  input  logic       src0_vld,
  output logic [2:0] dst
`ifdef GPC_7_3_OUT_REG_EN
  ,
  output logic [2:0] dst_q,
  output logic       dst_vld
`endif
);

  gpc7_3_in_t  in_bits;
  gpc7_3_out_t cnt;
  logic s0, c0, s1, c1, c2;

  assign in_bits = src0;

  gpc_full_adder u_fa0 (.a(in_bits[0]), .b(in_bits[1]), .ci(in_bits[2]), .s(s0),     .co(c0));
  gpc_full_adder u_fa1 (.a(in_bits[3]), .b(in_bits[4]), .ci(in_bits[5]), .s(s1),     .co(c1));
  gpc_full_adder u_fa2 (.a(s0),         .b(s1),         .ci(in_bits[6]), .s(cnt[0]), .co(c2));
  gpc_full_adder u_fa3 (.a(c0),         .b(c1),         .ci(c2),         .s(cnt[1]), .co(cnt[2]));

  assign dst = cnt;

`ifdef GPC_7_3_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_q   <= '0;
      dst_vld <= 1'b0;
    end else begin
      dst_vld <= src0_vld;
      if (src0_vld) dst_q <= cnt;
    end
  end
`else
  // Port list kept stable for tree generators; these inputs are intentionally unused here.
  logic unused_ctrl;
  assign unused_ctrl = ^{clk, rst, src0_vld};
`endif

endmodule

// File: tb/tb_gpc_7_3.sv
// Directed and exhaustive checks for gpc_7_3; register-stage sequences need GPC_7_3_OUT_REG_EN.
module tb_gpc_7_3;

  logic       clk;
  logic       rst;
  logic [6:0] src0;
  logic       src0_vld;
  logic [2:0] dst;
`ifdef GPC_7_3_OUT_REG_EN
  logic [2:0] dst_q;
  logic       dst_vld;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  gpc_7_3 dut (
    .clk      (clk),
    .rst      (rst),
    .src0     (src0),
    .src0_vld (src0_vld),
    .dst      (dst)
`ifdef GPC_7_3_OUT_REG_EN
    ,
    .dst_q    (dst_q),
    .dst_vld  (dst_vld)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] src;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [2:0] popcnt(input logic [6:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 7; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{"zero", 7'h00, 3'd0};
    vecs[1] = '{"all",  7'h7F, 3'd7};
    vecs[2] = '{"alt",  7'h55, 3'd4};
    vecs[3] = '{"msb",  7'h40, 3'd1};
    vecs[4] = '{"mid5", 7'h3E, 3'd5};

    rst = 1'b1;
    src0 = '0;
    src0_vld = 1'b0;

    for (int i = 0; i < 5; i++) begin
      src0 = vecs[i].src;
      #1;
      check(vecs[i].name, dst, vecs[i].exp);
    end

    for (int unsigned v = 0; v < 128; v++) begin
      src0 = v[6:0];
      #1;
      check($sformatf("sweep_%02h", v), dst, popcnt(v[6:0]));
    end

`ifdef GPC_7_3_OUT_REG_EN
    rst = 1'b1;
    src0 = 7'h7F;
    src0_vld = 1'b1;
    step();
    step();
    check("rst_dst_q", dst_q, 3'd0);
    check("rst_dst_vld", {2'b00, dst_vld}, 3'd1 - 3'd1);
    rst = 1'b0;
    src0 = 7'h7F; src0_vld = 1'b1;
    step();
    check("b2b0_dst_q", dst_q, 3'd7);
    check("b2b0_vld", {2'b00, dst_vld}, 3'd1);
    src0 = 7'h01;
    step();
    check("b2b1_dst_q", dst_q, 3'd1);
    check("b2b1_vld", {2'b00, dst_vld}, 3'd1);

    src0 = 7'h0F; src0_vld = 1'b1;
    step();
    check("tog0_dst_q", dst_q, 3'd4);
    check("tog0_vld", {2'b00, dst_vld}, 3'd1);
    src0 = 7'h7F; src0_vld = 1'b0;
    step();
    check("tog1_dst_q", dst_q, 3'd4);
    check("tog1_vld", {2'b00, dst_vld}, 3'd0);
    check("tog1_dst", dst, 3'd7);
    src0 = 7'h03; src0_vld = 1'b1;
    step();
    check("tog2_dst_q", dst_q, 3'd2);
    check("tog2_vld", {2'b00, dst_vld}, 3'd1);

    rst = 1'b1; src0 = 7'h7F; src0_vld = 1'b1;
    step();
    check("midrst_dst_q", dst_q, 3'd0);
    check("midrst_vld", {2'b00, dst_vld}, 3'd0);
    check("midrst_dst", dst, 3'd7);
    rst = 1'b0; src0_vld = 1'b0;
    step();
    check("post_rst_vld", {2'b00, dst_vld}, 3'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
